// File: rtl/clock_step_ctrl.sv
// Board-side clock/reset conditioner for the A09 CPU: debounced buttons,
// single-step or divided free-running CPU clock, held CPU reset, edge counter.
module clock_step_ctrl #(
    parameter int unsigned DebounceCycles  = 160000,
    parameter int unsigned RunDivisor      = 8000000,
    parameter int unsigned PulseCycles     = 4,
    parameter int unsigned ResetHoldCycles = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Step_Btn,
    input  logic        Mode_Btn,
    input  logic        Rst_Btn,
    input  logic        Halt,
    output logic        Cpu_Clk,
    output logic        Cpu_Reset,
    output logic        Run_Mode,
    output logic [15:0] Cyc_Count
);

    localparam int unsigned DbW   = $clog2(DebounceCycles + 1);
    localparam int unsigned DivW  = $clog2(RunDivisor + 1);
    localparam int unsigned PulW  = $clog2(PulseCycles + 1);
    localparam int unsigned HoldW = $clog2(ResetHoldCycles + 1);

    localparam logic [DbW-1:0]   DbLast   = DbW'(DebounceCycles - 1);
    localparam logic [DivW-1:0]  DivLast  = DivW'(RunDivisor - 1);
    localparam logic [PulW-1:0]  PulLast  = PulW'(PulseCycles - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(ResetHoldCycles - 1);

    localparam logic [1:0] RESETTING = 2'd0;
    localparam logic [1:0] STEP      = 2'd1;
    localparam logic [1:0] RUN       = 2'd2;

    // Bit 0 = step, bit 1 = mode, bit 2 = reset request
    logic [2:0]     btn_raw;
    logic [2:0]     sync1, sync2, deb, press;
    logic [DbW-1:0] db_cnt [3];

    assign btn_raw = {Rst_Btn, Mode_Btn, Step_Btn};

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            press <= '0;
            for (int unsigned i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            press <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DbLast) begin
                    db_cnt[i] <= '0;
                    deb[i]    <= sync2[i];
                    press[i]  <= sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic [1:0]       state, state_nxt;
    logic [HoldW-1:0] hold_cnt, hold_nxt;
    logic [DivW-1:0]  div_cnt, div_nxt;
    logic [PulW-1:0]  pulse_cnt, pulse_nxt;
    logic             pending, pend_nxt;
    logic             clk_nxt, rst_nxt;
    logic [15:0]      cyc_nxt;

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        div_nxt   = div_cnt;
        pulse_nxt = pulse_cnt;
        pend_nxt  = pending;
        clk_nxt   = Cpu_Clk;
        rst_nxt   = Cpu_Reset;
        if (press[2]) begin
            state_nxt = RESETTING;
            clk_nxt   = 1'b0;
            rst_nxt   = 1'b1;
            hold_nxt  = '0;
            div_nxt   = '0;
            pulse_nxt = '0;
            pend_nxt  = 1'b0;
        end else if (state == RESETTING) begin
            clk_nxt  = 1'b0;
            rst_nxt  = 1'b1;
            pend_nxt = 1'b0;
            if (hold_cnt == HoldLast) begin
                hold_nxt  = '0;
                rst_nxt   = 1'b0;
                state_nxt = STEP;
            end else begin
                hold_nxt = hold_cnt + 1'b1;
            end
        end else begin
            if (press[1]) pend_nxt = !pending;
            // A second press landing on the apply cycle cancels rather than applies
            if (pending && !press[1] && !Cpu_Clk) begin
                state_nxt = (state == RUN) ? STEP : RUN;
                div_nxt   = '0;
                pulse_nxt = '0;
                pend_nxt  = 1'b0;
            end else if (state == STEP) begin
                if (Cpu_Clk) begin
                    if (pulse_cnt == PulLast) begin
                        clk_nxt   = 1'b0;
                        pulse_nxt = '0;
                    end else begin
                        pulse_nxt = pulse_cnt + 1'b1;
                    end
                end else if (press[0]) begin
                    clk_nxt   = 1'b1;
                    pulse_nxt = '0;
                end
            end else begin
                if (div_cnt == DivLast) begin
                    div_nxt = '0;
                    if (Cpu_Clk) clk_nxt = 1'b0;
                    else if (!Halt) clk_nxt = 1'b1;
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
        end

        cyc_nxt = Cyc_Count;
        if (state_nxt == RESETTING) cyc_nxt = '0;
        else if (clk_nxt && !Cpu_Clk) cyc_nxt = Cyc_Count + 16'd1;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= RESETTING;
            hold_cnt  <= '0;
            div_cnt   <= '0;
            pulse_cnt <= '0;
            pending   <= 1'b0;
            Cpu_Clk   <= 1'b0;
            Cpu_Reset <= 1'b1;
            Run_Mode  <= 1'b0;
            Cyc_Count <= '0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_nxt;
            div_cnt   <= div_nxt;
            pulse_cnt <= pulse_nxt;
            pending   <= pend_nxt;
            Cpu_Clk   <= clk_nxt;
            Cpu_Reset <= rst_nxt;
            Run_Mode  <= (state_nxt == RUN);
            Cyc_Count <= cyc_nxt;
        end
    end

endmodule

// File: tb/tb_clock_step_ctrl.sv
// Directed bench for clock_step_ctrl with short debounce/divider/pulse/hold
// settings so every behaviour is reachable in a few hundred cycles.
module tb_clock_step_ctrl;

    logic        Clk = 1'b0;
    logic        Reset, Step_Btn, Mode_Btn, Rst_Btn, Halt;
    logic        Cpu_Clk, Cpu_Reset, Run_Mode;
    logic [15:0] Cyc_Count;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int          rises  = 0;
    int          hi_cyc = 0;
    logic        prev_clk = 1'b0;

    clock_step_ctrl #(
        .DebounceCycles (4),
        .RunDivisor     (3),
        .PulseCycles    (2),
        .ResetHoldCycles(5)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Step_Btn (Step_Btn),
        .Mode_Btn (Mode_Btn),
        .Rst_Btn  (Rst_Btn),
        .Halt     (Halt),
        .Cpu_Clk  (Cpu_Clk),
        .Cpu_Reset(Cpu_Reset),
        .Run_Mode (Run_Mode),
        .Cyc_Count(Cyc_Count)
    );

    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sample on the falling edge and track Cpu_Clk rising edges / high cycles
    task automatic tick();
        @(negedge Clk);
        if (Cpu_Clk && !prev_clk) rises++;
        if (Cpu_Clk) hi_cyc++;
        prev_clk = Cpu_Clk;
    endtask

    task automatic wait_rise(input string tag, input int bound);
        int start;
        int n;
        start = rises;
        n = 0;
        while (rises == start && n < bound) begin
            tick();
            n++;
        end
        check_val(tag, rises - start, 1);
    endtask

    // Hold Step_Btn for 10 cycles; returns the tick on which Cpu_Clk rose
    task automatic step_press(output int rise_i);
        int r;
        rise_i = 0;
        Step_Btn = 1'b1;
        for (int i = 1; i <= 22; i++) begin
            if (i == 11) Step_Btn = 1'b0;
            r = rises;
            tick();
            if (rises != r && rise_i == 0) rise_i = i;
        end
    endtask

    initial begin
        int n;
        int c;
        int ri;
        int r;
        int pc;
        int seen;
        int rcount;
        int rise_at [4];

        Reset = 1'b0; Step_Btn = 1'b0; Mode_Btn = 1'b0; Rst_Btn = 1'b0; Halt = 1'b0;

        // Board reset
        repeat (3) tick();
        check_val("brst_clk", Cpu_Clk, 0);
        check_val("brst_rst", Cpu_Reset, 1);
        check_val("brst_mode", Run_Mode, 0);
        check_val("brst_cyc", Cyc_Count, 0);
        Reset = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if (!Cpu_Reset) break;
        end
        check_val("brst_hold", n, 5);
        check_val("brst_clk_after", Cpu_Clk, 0);

        // 3-cycle glitch must be rejected
        rises = 0; hi_cyc = 0;
        Step_Btn = 1'b1;
        repeat (3) tick();
        Step_Btn = 1'b0;
        repeat (10) tick();
        check_val("glitch_rises", rises, 0);
        check_val("glitch_hi", hi_cyc, 0);

        // Clean step press: strobe at edge 6, Cpu_Clk high on edges 7..8
        rises = 0; hi_cyc = 0;
        step_press(ri);
        check_val("step_lat", ri, 7);
        check_val("step_rises", rises, 1);
        check_val("step_hi", hi_cyc, 2);
        check_val("step_cyc", Cyc_Count, 1);

        // Enter RUN: apply at edge 8, rises at 11,17,23,29
        rises = 0;
        Mode_Btn = 1'b1;
        for (int k = 0; k < 4; k++) rise_at[k] = 0;
        for (int i = 1; i <= 60; i++) begin
            if (i == 9) Mode_Btn = 1'b0;
            r = rises;
            tick();
            if (rises != r && rises <= 4) rise_at[rises-1] = i;
            if (i == 7) check_val("run_mode_pre", Run_Mode, 0);
            if (i == 8) check_val("run_mode_on", Run_Mode, 1);
            if (i == 14) check_val("run_half", Cpu_Clk, 0);
            if (rises == 4) break;
        end
        for (int k = 0; k < 4; k++) check_val($sformatf("run_rise%0d", k), rise_at[k], 11 + 6 * k);
        check_val("run_cyc", Cyc_Count, 5);

        // Halt raised during a high phase: phase completes, then clock holds low
        Halt = 1'b1;
        n = 0;
        while (Cpu_Clk && n < 10) begin
            tick();
            n++;
        end
        check_val("halt_fall_edge", n, 3);
        c = Cyc_Count;
        rises = 0;
        repeat (15) tick();
        check_val("halt_rises", rises, 0);
        check_val("halt_cyc", Cyc_Count, c);
        check_val("halt_clk", Cpu_Clk, 0);
        Halt = 1'b0;
        wait_rise("halt_resume", 10);
        check_val("halt_resume_cyc", Cyc_Count, c + 1);

        // Back to STEP
        Mode_Btn = 1'b1;
        repeat (8) tick();
        Mode_Btn = 1'b0;
        repeat (12) tick();
        check_val("step_mode_back", Run_Mode, 0);
        check_val("step_mode_clk", Cpu_Clk, 0);

        // Mode strobe lands on the edge the step pulse rises
        Step_Btn = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            if (i == 2) Mode_Btn = 1'b1;
            if (i == 11) Step_Btn = 1'b0;
            if (i == 12) Mode_Btn = 1'b0;
            tick();
            if (i == 6) check_val("tog_clk6", Cpu_Clk, 0);
            if (i == 7) check_val("tog_clk7", Cpu_Clk, 1);
            if (i == 8) check_val("tog_clk8", Cpu_Clk, 1);
            if (i == 9) begin
                check_val("tog_clk9", Cpu_Clk, 0);
                check_val("tog_mode9", Run_Mode, 0);
            end
            if (i == 10) check_val("tog_mode10", Run_Mode, 1);
        end

        // Reset request while Cpu_Clk is high in RUN
        wait_rise("rst_sync", 12);
        Rst_Btn = 1'b1;
        seen = 0; ri = 0; rcount = 0;
        for (int i = 1; i <= 30; i++) begin
            if (i == 9) Rst_Btn = 1'b0;
            pc = Cpu_Clk;
            tick();
            if (seen == 0 && Cpu_Reset) begin
                seen = 1;
                ri = i;
                check_val("rst_midhigh", pc, 1);
                check_val("rst_clk", Cpu_Clk, 0);
                check_val("rst_mode", Run_Mode, 0);
                check_val("rst_cyc", Cyc_Count, 0);
            end
            if (Cpu_Reset) rcount++;
        end
        check_val("rst_lat", ri, 7);
        check_val("rst_len", rcount, 5);

        // Counter wrap; Halt asserted to show it does not block a step
        force dut.Cyc_Count = 16'hFFFF;
        repeat (2) tick();
        release dut.Cyc_Count;
        tick();
        check_val("wrap_pre", Cyc_Count, 16'hFFFF);
        Halt = 1'b1;
        rises = 0;
        step_press(ri);
        check_val("wrap_rises", rises, 1);
        check_val("wrap_cyc", Cyc_Count, 0);
        Halt = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
